// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART-driven ALU frame sequencer.
package uart_alu_pkg;

    localparam logic [3:0] SYNC_NIBBLE = 4'hA;

    typedef logic [3:0] opcode_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GET_A     = 3'd1,
        GET_B     = 3'd2,
        ISSUE     = 3'd3,
        WAIT_DONE = 3'd4,
        RESPOND   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/uart_alu_sequencer_if.sv
// Byte-stream, ALU and status bundle between the sequencer and its environment.
interface uart_alu_sequencer_if;
    import uart_alu_pkg::*;

    logic       rx_valid;
    logic [7:0] rx_data;
    opcode_t    alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_start;
    logic       alu_done;
    logic [7:0] alu_result;
    logic       res_valid;
    logic [7:0] res_data;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    modport master (
        input  rx_valid, rx_data, alu_done, alu_result,
        output alu_op, alu_a, alu_b, alu_start, res_valid, res_data,
               busy, frame_err, overrun
    );

    modport slave (
        output rx_valid, rx_data, alu_done, alu_result,
        input  alu_op, alu_a, alu_b, alu_start, res_valid, res_data,
               busy, frame_err, overrun
    );

endinterface

// File: rtl/seq_timeout_counter.sv
// Clear/enable counter that flags expiry on the LIMIT-th enabled cycle.
module seq_timeout_counter #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Expiry is not masked by clear so a same-cycle byte cannot rescue a stale frame.
    assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/uart_alu_sequencer.sv
// Collects {A,op}/A/B byte frames, launches the ALU, and returns the result
// with gap, sync, ALU-timeout and overrun reporting.
module uart_alu_sequencer
    import uart_alu_pkg::*;
#(
    parameter int CLOCK_FREQ  = 50000000,
    parameter int BAUD_RATE   = 115200,
    parameter int GAP_BITS    = 30,
    parameter int ALU_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_alu_sequencer_if.master   bus
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int GAP_LIMIT    = CLKS_PER_BIT * GAP_BITS;

    seq_state_t state, state_nx;
    opcode_t    op_q, op_nx;
    logic [7:0] a_q, a_nx, b_q, b_nx, res_q, res_nx;
    logic       ferr_q, ferr_nx, ovr_q, ovr_nx;
    logic       in_get, in_alu, gap_exp, alu_exp;

    assign in_get = (state == GET_A) || (state == GET_B);
    assign in_alu = (state == ISSUE) || (state == WAIT_DONE);

    seq_timeout_counter #(.LIMIT(GAP_LIMIT)) u_gap (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!in_get || bus.rx_valid),
        .enable (in_get),
        .expire (gap_exp)
    );

    // Counts from the ISSUE cycle so expiry lands ALU_TIMEOUT cycles after alu_start.
    seq_timeout_counter #(.LIMIT(ALU_TIMEOUT)) u_alu (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!in_alu),
        .enable (in_alu),
        .expire (alu_exp)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            op_q   <= op_nx;
            a_q    <= a_nx;
            b_q    <= b_nx;
            res_q  <= res_nx;
            ferr_q <= ferr_nx;
            ovr_q  <= ovr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        op_nx    = op_q;
        a_nx     = a_q;
        b_nx     = b_q;
        res_nx   = res_q;
        ferr_nx  = 1'b0;
        ovr_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data[7:4] == SYNC_NIBBLE) begin
                        op_nx    = bus.rx_data[3:0];
                        state_nx = GET_A;
                    end else begin
                        ferr_nx = !ferr_q;
                    end
                end
            end
            GET_A: begin
                if (gap_exp) begin
                    ferr_nx  = !ferr_q;
                    state_nx = IDLE;
                end else if (bus.rx_valid) begin
                    a_nx     = bus.rx_data;
                    state_nx = GET_B;
                end
            end
            GET_B: begin
                if (gap_exp) begin
                    ferr_nx  = !ferr_q;
                    state_nx = IDLE;
                end else if (bus.rx_valid) begin
                    b_nx     = bus.rx_data;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                ovr_nx   = bus.rx_valid && !ovr_q;
                state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                ovr_nx = bus.rx_valid && !ovr_q;
                if (bus.alu_done) begin
                    res_nx   = bus.alu_result;
                    state_nx = RESPOND;
                end else if (alu_exp) begin
                    ferr_nx  = !ferr_q;
                    state_nx = IDLE;
                end
            end
            RESPOND: begin
                ovr_nx   = bus.rx_valid && !ovr_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.alu_op    = op_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_start = (state == ISSUE);
    assign bus.res_valid = (state == RESPOND);
    assign bus.res_data  = res_q;
    assign bus.busy      = (state != IDLE);
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Directed checks of framing, ALU handshake, timeouts, overrun and reset abort.
module tb_uart_alu_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    uart_alu_sequencer_if bus ();

    uart_alu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Returns at the negedge following the edge that sampled the byte.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    // Returns in the cycle after alu_done was sampled.
    task automatic alu_reply(input logic [7:0] r);
        @(negedge clk);
        bus.alu_done   = 1'b1;
        bus.alu_result = r;
        @(negedge clk);
        bus.alu_done   = 1'b0;
        bus.alu_result = 8'h00;
    endtask

    task automatic frame(input logic [7:0] h, input logic [7:0] a, input logic [7:0] b);
        send_byte(h);
        idle(2);
        send_byte(a);
        idle(3);
        send_byte(b);
    endtask

    initial begin
        int  n;
        bit  seen;
        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'h00;
        bus.alu_done   = 1'b0;
        bus.alu_result = 8'h00;

        // Reset state
        idle(3);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_start", bus.alu_start, 1'b0);
        chk("rst_resv", bus.res_valid, 1'b0);
        chk("rst_ferr", bus.frame_err, 1'b0);
        chk("rst_ovr", bus.overrun, 1'b0);
        chk("rst_opab", {bus.alu_op, bus.alu_a, 4'h0}, 16'h0);
        chk("rst_bres", {bus.alu_b, bus.res_data}, 16'h0);
        rst_n = 1'b1;
        idle(1);

        // Basic frame A3 12 34, ALU answers 46 three cycles after start
        frame(8'hA3, 8'h12, 8'h34);
        chk("f1_start", bus.alu_start, 1'b1);
        chk("f1_op", bus.alu_op, 4'h3);
        chk("f1_a", bus.alu_a, 8'h12);
        chk("f1_b", bus.alu_b, 8'h34);
        idle(1);
        chk("f1_start_off", bus.alu_start, 1'b0);
        idle(1);
        alu_reply(8'h46);
        chk("f1_resv", bus.res_valid, 1'b1);
        chk("f1_res", bus.res_data, 8'h46);
        idle(1);
        chk("f1_resv_off", bus.res_valid, 1'b0);
        chk("f1_idle", bus.busy, 1'b0);

        // Bad sync nibble
        send_byte(8'h5A);
        chk("sync_ferr", bus.frame_err, 1'b1);
        chk("sync_busy", bus.busy, 1'b0);
        idle(1);
        chk("sync_ferr_off", bus.frame_err, 1'b0);

        // Gap timeout after A5 07: error exactly 13020 cycles after the 07 byte
        send_byte(8'hA5);
        idle(1);
        send_byte(8'h07);
        n = 0;
        seen = 1'b0;
        while (n < 13100 && !seen) begin
            @(negedge clk);
            n++;
            seen = bus.frame_err;
        end
        chk("gap_cycles", 16'(n), 16'd13020);
        chk("gap_busy", bus.busy, 1'b0);
        frame(8'hA1, 8'h02, 8'h03);
        chk("gap_f_opab", {bus.alu_op, bus.alu_a, 4'h0}, 16'h1020);
        chk("gap_f_b", bus.alu_b, 8'h03);
        alu_reply(8'h05);
        chk("gap_f_resv", bus.res_valid, 1'b1);
        chk("gap_f_res", bus.res_data, 8'h05);

        // ALU never answers: error 64 cycles after alu_start, result held
        idle(2);
        frame(8'hA2, 8'h10, 8'h20);
        chk("to_start", bus.alu_start, 1'b1);
        n = 0;
        seen = 1'b0;
        while (n < 200 && !bus.frame_err) begin
            @(negedge clk);
            n++;
            if (bus.res_valid) seen = 1'b1;
        end
        chk("to_cycles", 16'(n), 16'd64);
        chk("to_no_resv", seen, 1'b0);
        chk("to_res_held", bus.res_data, 8'h05);
        chk("to_busy", bus.busy, 1'b0);
        idle(1);
        chk("to_ferr_off", bus.frame_err, 1'b0);

        // Byte FF during WAIT_DONE
        frame(8'hA4, 8'h08, 8'h09);
        idle(1);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hFF;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        chk("ovr_pulse", bus.overrun, 1'b1);
        chk("ovr_busy", bus.busy, 1'b1);
        idle(1);
        chk("ovr_off", bus.overrun, 1'b0);
        chk("ovr_b_kept", bus.alu_b, 8'h09);
        alu_reply(8'h11);
        chk("ovr_resv", bus.res_valid, 1'b1);
        chk("ovr_res", bus.res_data, 8'h11);

        // Reset while in GET_B
        idle(2);
        send_byte(8'hA6);
        send_byte(8'h01);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mr_busy", bus.busy, 1'b0);
        chk("mr_opab", {bus.alu_op, bus.alu_a, 4'h0}, 16'h0);
        chk("mr_bres", {bus.alu_b, bus.res_data}, 16'h0);
        chk("mr_pulses", {bus.alu_start, bus.res_valid, bus.frame_err, bus.overrun}, 4'h0);
        alu_reply(8'h77);
        chk("mr_late_done", {bus.res_valid, bus.busy}, 2'b00);
        chk("mr_late_res", bus.res_data, 8'h00);
        frame(8'hA7, 8'h03, 8'h04);
        chk("mr_f_start", bus.alu_start, 1'b1);
        chk("mr_f_opab", {bus.alu_op, bus.alu_a, 4'h0}, 16'h7030);
        alu_reply(8'h5C);
        chk("mr_f_resv", bus.res_valid, 1'b1);
        chk("mr_f_res", bus.res_data, 8'h5C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
